ex_mdu_ctrl: RTL
================

EX_MDU_CTRL -- requirements
Module: ex_mdu_ctrl

Interface
REQ-001 SHALL have clock and reset as decided: one clock, `clk`; reset `rst_n`, asynchronous, active-low.
REQ-002 Ports (name, direction, width, meaning):
- `clk`, in, 1: clock; all state updates on the rising edge.
- `rst_n`, in, 1: asynchronous active-low reset.
- `flush`, in, 1: pipeline flush; aborts any operation in progress.
- `start`, in, 1: the ID/EX register holds an M-extension operation.
- `op`, in, 3: operation code. 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
- `rs1_data`, in, 32: operand a.
- `rs2_data`, in, 32: operand b.
- `stall`, out, 1: freezes the IF/ID/EX pipeline registers.
- `done`, out, 1: `result` is valid this cycle.
- `result`, out, 32: operation result, driven to EX/MEM.
- `busy`, out, 1: state is not IDLE.

Function
REQ-003 SHALL implement an FSM with three states:
- IDLE: `start` && !`flush` -> BUSY, or -> DONE when a fast path applies.
- BUSY: `cnt` == 31 -> DONE.
- DONE -> IDLE unconditionally.
REQ-004 SHALL, when `start` is accepted in IDLE, latch `op` and the operands, and clear the 5-bit counter `cnt`.
REQ-005 SHALL perform one radix-2 iteration per BUSY cycle, 32 iterations in total.
- Multiply: shift-add on operand magnitudes.
- Divide: restoring, on operand magnitudes.
REQ-006 SHALL make the signed magnitude-to-result correction in DONE, not in BUSY.
- MULH: both operands signed.
- MULHSU: a signed, b unsigned.
- DIV/REM: quotient sign is sign(a) XOR sign(b); remainder sign is sign(a).
REQ-007 SHALL give a latency of 33 cycles from the `start` acceptance edge to `done` high on the normal path.
REQ-008 SHALL, on divide by zero (`rs2_data`==0), go IDLE -> DONE directly (latency 1).
- Quotient: 0xFFFFFFFF.
- Remainder: `rs1_data`.
REQ-009 SHALL, on signed overflow (DIV/REM with a=0x80000000, b=0xFFFFFFFF), take the fast path.
- Quotient: 0x80000000.
- Remainder: 0.
REQ-010 SHALL drive `stall` = (IDLE && `start` && !`flush`) || BUSY; `stall` SHALL be 0 in DONE, so the pipeline advances on the `done` cycle.
REQ-011 SHALL assert `done` for exactly one cycle, in DONE only.
REQ-012 SHALL hold `result` stable outside DONE, equal to the last completed value.
REQ-013 SHALL ignore `start` while in BUSY or DONE.
REQ-014 SHALL treat `flush` in any state as highest priority: next state IDLE, and `done` is suppressed the following cycle.
REQ-015 SHALL give `flush` priority when `flush` and `start` are both high in IDLE: nothing is accepted and `stall` stays 0.
REQ-016 SHALL wrap `cnt` modulo 32; `cnt` is only compared to 31 in BUSY.

Reset
REQ-017 SHALL, with `rst_n` low, drive the following immediately, independent of `clk`:
- state IDLE, `cnt` 0, operand and accumulator registers 0.
- `result` 0, `done` 0, `stall` 0, `busy` 0.
REQ-018 SHALL abandon an operation interrupted by reset mid-BUSY; no `done` is produced after `rst_n` rises.

Configuration
REQ-019 SHALL compile the divider datapath in only when `MDU_DIV_EN` is defined.
REQ-020 SHALL, without `MDU_DIV_EN`, handle ops 4-7 as follows:
- take IDLE -> DONE with latency 1;
- return `result` 0;
- make no divider registers exist;
- leave MUL* behaviour identical to the configuration with `MDU_DIV_EN`.

Structure
REQ-021 SHALL take the following from the shared package `mdu_pkg`:
- enum `mdu_op_t` holding the op encodings;
- FSM state enum `mdu_state_t`;
- constant `MDU_ITER` = 32.
REQ-022 SHALL place the per-cycle shift-add/subtract step in one sub-module, `mdu_iter_step`. It is combinational, with inputs accumulator, operand, and mode, and outputs the next accumulator.
REQ-023 SHALL leave `ex_stage` unchanged; the top-level muxes `result` over `alu_result` when `done` is high.

Verification
REQ-024 Directed scenarios the bench SHALL cover:
- MUL 7 x 6 -> `done` 33 cycles after acceptance, `result` 42, `stall` high for 33 cycles.
- MULH 0xFFFFFFFF x 0xFFFFFFFF -> `result` 0x00000000; MULHU with the same operands -> 0xFFFFFFFE.
- DIV -7 / 2 -> 0xFFFFFFFD; REM -7 / 2 -> 0xFFFFFFFF; both at latency 33.
- DIVU 5 / 0 -> 0xFFFFFFFF after 1 cycle; REM 0x80000000 / 0xFFFFFFFF -> 0 after 1 cycle.
- `flush` at BUSY cycle 10 -> IDLE next cycle, `done` never asserted; a new `start` accepted 1 cycle later completes correctly.
- `rst_n` pulsed low at BUSY cycle 20 -> all outputs 0 asynchronously, no `done` afterward. Without `MDU_DIV_EN`: DIV -> `result` 0 after 1 cycle.

Source files
------------

// File: rtl/mdu_pkg.sv
// Shared types and constants for the M-extension multiply/divide controller.
package mdu_pkg;

  localparam int MDU_ITER = 32;

  typedef enum logic [2:0] {
    OP_MUL    = 3'd0,
    OP_MULH   = 3'd1,
    OP_MULHSU = 3'd2,
    OP_MULHU  = 3'd3,
    OP_DIV    = 3'd4,
    OP_DIVU   = 3'd5,
    OP_REM    = 3'd6,
    OP_REMU   = 3'd7
  } mdu_op_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BUSY,
    ST_DONE
  } mdu_state_t;

  typedef enum logic {
    STEP_MUL,
    STEP_DIV
  } step_mode_t;

  function automatic logic op_signed_a(input mdu_op_t o);
    return o inside {OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
  endfunction

  function automatic logic op_signed_b(input mdu_op_t o);
    return o inside {OP_MULH, OP_DIV, OP_REM};
  endfunction

endpackage

// File: rtl/mdu_iter_step.sv
// One radix-2 iteration: shift-add multiply or restoring divide on magnitudes.
// The divide step only exists when MDU_DIV_EN is defined.
module mdu_iter_step
  import mdu_pkg::*;
(
  input  logic [63:0] acc,
  input  logic [31:0] operand,
  input  step_mode_t  mode,
  output logic [63:0] acc_next
);

  // Multiply: acc = {partial product high, remaining multiplier bits}.
  logic [32:0] sum;
  assign sum = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, operand} : 33'd0);

`ifdef MDU_DIV_EN
  // Divide: acc = {partial remainder, dividend bits / quotient bits}.
  logic [32:0] rem_shift;
  logic [32:0] diff;
  assign rem_shift = {acc[63:32], acc[31]};
  assign diff      = rem_shift - {1'b0, operand};

  always_comb begin
    acc_next = {sum, acc[31:1]};
    if (mode == STEP_DIV) begin
      if (diff[32]) acc_next = {rem_shift[31:0], acc[30:0], 1'b0};
      else          acc_next = {diff[31:0], acc[30:0], 1'b1};
    end
  end
`else
  logic unused_mode;
  assign unused_mode = mode;
  assign acc_next    = {sum, acc[31:1]};
`endif

endmodule

// File: rtl/ex_mdu_ctrl.sv
// Iterative multiply/divide unit for the EX stage; stalls the front pipeline while busy.
// Divider datapath is present only when MDU_DIV_EN is defined.
module ex_mdu_ctrl
  import mdu_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        flush,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] rs1_data,
  input  logic [31:0] rs2_data,
  output logic        stall,
  output logic        done,
  output logic [31:0] result,
  output logic        busy
);

  mdu_state_t  state_reg, state_next;
  logic [4:0]  cnt_reg;
  mdu_op_t     op_reg;
  logic        a_neg_reg, b_neg_reg;
  logic [63:0] acc_reg;
  logic [31:0] opnd_reg;
  logic        fast_reg;
  logic [31:0] fast_val_reg;
  logic [31:0] result_reg;

  mdu_op_t     op_in;
  logic        accept;
  logic        a_neg, b_neg;
  logic [31:0] mag_a, mag_b;
  logic        fast;
  logic [31:0] fast_val;
  logic [63:0] acc_step;
  logic [63:0] prod_fix;
  logic [31:0] corr;

  assign op_in  = mdu_op_t'(op);
  assign accept = (state_reg == ST_IDLE) && start && !flush;
  assign a_neg  = op_signed_a(op_in) && rs1_data[31];
  assign b_neg  = op_signed_b(op_in) && rs2_data[31];
  assign mag_a  = a_neg ? (32'd0 - rs1_data) : rs1_data;
  assign mag_b  = b_neg ? (32'd0 - rs2_data) : rs2_data;

`ifdef MDU_DIV_EN
  logic div_zero, div_ovf;
  assign div_zero = op_in[2] && (rs2_data == 32'd0);
  assign div_ovf  = (op_in == OP_DIV || op_in == OP_REM) &&
                    (rs1_data == 32'h8000_0000) && (rs2_data == 32'hFFFF_FFFF);
  assign fast     = div_zero || div_ovf;

  always_comb begin
    fast_val = 32'd0;
    if (div_zero) fast_val = (op_in == OP_DIV || op_in == OP_DIVU) ? 32'hFFFF_FFFF : rs1_data;
    else if (div_ovf && op_in == OP_DIV) fast_val = 32'h8000_0000;
  end
`else
  // Without a divider every divide/remainder completes immediately with zero.
  assign fast     = op_in[2];
  assign fast_val = 32'd0;
`endif

  mdu_iter_step u_step (
    .acc      (acc_reg),
    .operand  (opnd_reg),
    .mode     (op_reg[2] ? STEP_DIV : STEP_MUL),
    .acc_next (acc_step)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= ST_IDLE;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    stall      = 1'b0;
    done       = 1'b0;
    busy       = (state_reg != ST_IDLE);
    if (flush) begin
      state_next = ST_IDLE;
    end else begin
      case (state_reg)
        ST_IDLE: if (start) state_next = fast ? ST_DONE : ST_BUSY;
        ST_BUSY: if (cnt_reg == 5'(MDU_ITER - 1)) state_next = ST_DONE;
        ST_DONE: state_next = ST_IDLE;
        default: state_next = ST_IDLE;
      endcase
    end
    // Gated by rst_n so stall drops the moment reset asserts, even with start high.
    stall = rst_n && (accept || (state_reg == ST_BUSY));
    done  = (state_reg == ST_DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg      <= '0;
      op_reg       <= OP_MUL;
      a_neg_reg    <= 1'b0;
      b_neg_reg    <= 1'b0;
      acc_reg      <= '0;
      opnd_reg     <= '0;
      fast_reg     <= 1'b0;
      fast_val_reg <= '0;
      result_reg   <= '0;
    end else begin
      if (accept) begin
        op_reg       <= op_in;
        a_neg_reg    <= a_neg;
        b_neg_reg    <= b_neg;
        // Multiply iterates over b's bits adding a; divide shifts a through the remainder.
        acc_reg      <= {32'd0, op_in[2] ? mag_a : mag_b};
        opnd_reg     <= op_in[2] ? mag_b : mag_a;
        cnt_reg      <= '0;
        fast_reg     <= fast;
        fast_val_reg <= fast_val;
      end else if (state_reg == ST_BUSY) begin
        acc_reg <= acc_step;
        cnt_reg <= cnt_reg + 5'd1;
      end
      if (state_reg == ST_DONE) result_reg <= corr;
    end
  end

  // Sign correction of the magnitude result happens only while presenting it.
  assign prod_fix = (a_neg_reg ^ b_neg_reg) ? (64'd0 - acc_reg) : acc_reg;

  always_comb begin
    corr = '0;
    if (fast_reg) begin
      corr = fast_val_reg;
    end else begin
      case (op_reg)
        OP_MUL:                       corr = acc_reg[31:0];
        OP_MULH, OP_MULHSU, OP_MULHU: corr = prod_fix[63:32];
`ifdef MDU_DIV_EN
        OP_DIV, OP_DIVU: corr = (a_neg_reg ^ b_neg_reg) ? (32'd0 - acc_reg[31:0]) : acc_reg[31:0];
        OP_REM, OP_REMU: corr = a_neg_reg ? (32'd0 - acc_reg[63:32]) : acc_reg[63:32];
`endif
        default: corr = '0;
      endcase
    end
  end

  assign result = (state_reg == ST_DONE) ? corr : result_reg;

endmodule
